qcw_burst_sequencer: RTL

Sequences the QCW bridge driver through complete bursts. Accepts a fire request, latches the burst configuration and pulses the driver's start. Over the burst it ramps the driver's phase_shift input once per resonant cycle, watches for stalls and aborts, and enforces a minimum off-time between bursts. It sits between the host/interrupter logic and the bridge driver and is the only block that drives the driver's start, halt, phase_shift and cycle_limit inputs.

---
 rtl/qcw_burst_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/qcw_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qcw_burst_sequencer
// Purpose  : Runs complete QCW bridge-driver bursts: arm, start, per-cycle phase
//            ramp, stall/abort/fault handling and minimum off-time between bursts.
// Revision : 1.0 - initial release
// ============================================================================
module qcw_burst_sequencer #(
    parameter int PHASE_MIN     = 50,
    parameter int PHASE_MAX     = 254,
    parameter int WDT_CLKS      = 4096,
    parameter int READY_TIMEOUT = 1024,
    parameter int HOLDOFF_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire,
    input  logic                 abort,
    input  logic                 fault_clear,
    input  logic [15:0]          cfg_cycles,
    input  logic [7:0]           cfg_phase_start,
    input  logic [7:0]           cfg_phase_end,
    input  logic [7:0]           cfg_phase_step,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    input  logic                 drv_ready,
    input  logic                 drv_cycle_finished,
    input  logic                 drv_fault,
    output logic                 drv_start,
    output logic                 drv_halt,
    output logic [7:0]           drv_phase_shift,
    output logic [15:0]          drv_cycle_limit,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 fault_flag,
    output logic [1:0]           fault_code,
    output logic [15:0]          burst_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_START, S_RUN, S_STOP_OK, S_STOP_ABORT, S_HOLDOFF, S_FAULT
    } state_t;

    localparam int WDT_W = $clog2(WDT_CLKS + 1);
    localparam int RDY_W = $clog2(READY_TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CLKS - 1);
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             phase_q, phase_d;
    logic [7:0]             end_q, end_d;
    logic [7:0]             step_q, step_d;
    logic                   up_q, up_d;
    logic [HOLDOFF_W-1:0]   hold_cfg_q, hold_cfg_d;
    logic [HOLDOFF_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WDT_W-1:0]       wdt_q, wdt_d;
    logic [RDY_W-1:0]       rdy_cnt_q, rdy_cnt_d;
    logic                   ready_prev_q;
    logic [15:0]            limit_q, limit_d;
    logic [15:0]            count_q, count_d;
    logic [1:0]             code_q, code_d;
    logic                   start_q, halt_q, busy_q, done_q, fflag_q;

    function automatic logic [7:0] clamp_phase(input logic [8:0] v);
        if (v < 9'(PHASE_MIN))
            return 8'(PHASE_MIN);
        else if (v > 9'(PHASE_MAX))
            return 8'(PHASE_MAX);
        else
            return v[7:0];
    endfunction

    // Ramp in 9 bits so overshoot/borrow is visible before clamping.
    logic [8:0] w_sum, w_diff, w_next9;
    always_comb begin
        w_sum  = {1'b0, phase_q} + {1'b0, step_q};
        w_diff = {1'b0, phase_q} - {1'b0, step_q};
        if (up_q)
            w_next9 = (w_sum > {1'b0, end_q}) ? {1'b0, end_q} : w_sum;
        else
            w_next9 = (w_diff[8] || (w_diff < {1'b0, end_q})) ? {1'b0, end_q} : w_diff;
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        end_d      = end_q;
        step_d     = step_q;
        up_d       = up_q;
        hold_cfg_d = hold_cfg_q;
        hold_cnt_d = hold_cnt_q;
        wdt_d      = wdt_q;
        rdy_cnt_d  = rdy_cnt_q;
        limit_d    = limit_q;
        code_d     = code_q;
        case (state_q)
            S_IDLE: if (fire) begin
                end_d      = cfg_phase_end;
                step_d     = cfg_phase_step;
                up_d       = (cfg_phase_end >= cfg_phase_start);
                hold_cfg_d = cfg_holdoff;
                limit_d    = cfg_cycles;
                phase_d    = clamp_phase({1'b0, cfg_phase_start});
                rdy_cnt_d  = '0;
                state_d    = S_ARM;
            end
            S_ARM: begin
                if (drv_ready) begin
                    state_d = S_START;
                end else if (rdy_cnt_q == RDY_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'd3;
                end else begin
                    rdy_cnt_d = rdy_cnt_q + 1'b1;
                end
            end
            S_START: begin
                wdt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (drv_cycle_finished) begin
                    wdt_d   = '0;
                    phase_d = clamp_phase(w_next9);
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
                if (abort) begin
                    rdy_cnt_d = '0;
                    state_d   = S_STOP_ABORT;
                end else if (!drv_cycle_finished && (wdt_q == WDT_LAST)) begin
                    state_d = S_FAULT;
                    code_d  = 2'd2;
                end else if (drv_ready && !ready_prev_q) begin
                    state_d = S_STOP_OK;
                end
            end
            S_STOP_OK: begin
                hold_cnt_d = hold_cfg_q;
                state_d    = S_HOLDOFF;
            end
            S_STOP_ABORT: begin
                if (drv_ready) begin
                    hold_cnt_d = hold_cfg_q;
                    state_d    = S_HOLDOFF;
                end else if (rdy_cnt_q == RDY_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'd3;
                end else begin
                    rdy_cnt_d = rdy_cnt_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (hold_cnt_q == '0)
                    state_d = S_IDLE;
                else
                    hold_cnt_d = hold_cnt_q - 1'b1;
            end
            S_FAULT: if (fault_clear && !drv_fault) begin
                code_d     = 2'd0;
                hold_cnt_d = hold_cfg_q;
                state_d    = S_HOLDOFF;
            end
            default: state_d = S_IDLE;
        endcase
        // Driver fault outranks everything; an existing fault keeps its original code.
        if (drv_fault && (state_q != S_IDLE) && (state_q != S_FAULT)) begin
            state_d = S_FAULT;
            code_d  = 2'd1;
        end
        count_d = (state_d == S_STOP_OK) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= 8'(PHASE_MIN);
            end_q        <= '0;
            step_q       <= '0;
            up_q         <= 1'b0;
            hold_cfg_q   <= '0;
            hold_cnt_q   <= '0;
            wdt_q        <= '0;
            rdy_cnt_q    <= '0;
            ready_prev_q <= 1'b0;
            limit_q      <= '0;
            count_q      <= '0;
            code_q       <= '0;
            start_q      <= 1'b0;
            halt_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fflag_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            end_q        <= end_d;
            step_q       <= step_d;
            up_q         <= up_d;
            hold_cfg_q   <= hold_cfg_d;
            hold_cnt_q   <= hold_cnt_d;
            wdt_q        <= wdt_d;
            rdy_cnt_q    <= rdy_cnt_d;
            ready_prev_q <= drv_ready;
            limit_q      <= limit_d;
            count_q      <= count_d;
            code_q       <= code_d;
            start_q      <= (state_d == S_START);
            halt_q       <= (state_d == S_STOP_ABORT) || (state_d == S_FAULT);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_FAULT);
            done_q       <= (state_d == S_STOP_OK);
            fflag_q      <= (state_d == S_FAULT);
        end
    end

    assign drv_start       = start_q;
    assign drv_halt        = halt_q;
    assign drv_phase_shift = phase_q;
    assign drv_cycle_limit = limit_q;
    assign busy            = busy_q;
    assign burst_done      = done_q;
    assign fault_flag      = fflag_q;
    assign fault_code      = code_q;
    assign burst_count     = count_q;

endmodule
`default_nettype wire
